q_update_core: RTL and testbench
================================

Name: q_update_core

Overview:
- Pipelined Q-learning update stage that sits directly downstream of the max-reduction tree.
- Consumes max_q, which is max over next-state actions of Q(s',a'), together with the reward and the current Q(s,a).
- Computes Q_new = Q + ALPHA*(R + GAMMA*max_q - Q) in signed fixed point, saturates the result, and presents it with its Q-table index for write-back.
- Valid/ready handshake on both sides; 4-cycle latency; one update per cycle at full throughput.

Parameters:
- DATA_WIDTH, 32, width of all Q/reward values; signed two's complement.
- FRAC_BITS, 16, fractional bits of the fixed-point format (Q16.16 at defaults).
- ADDR_WIDTH, 10, width of the state-action index carried alongside the data.
- ALPHA, 32'h0000_1999, learning rate in the same fixed-point format (~0.1).
- GAMMA, 32'h0000_E666, discount factor in the same fixed-point format (~0.9).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  global enable; when 0, all pipeline and counter state holds.
- in_valid  in  1  input tuple valid.
- in_ready  out  1  stage can accept the input tuple.
- in_reward  in  DATA_WIDTH  reward R.
- in_max_q  in  DATA_WIDTH  max_q from the max-reduction tree.
- in_q_old  in  DATA_WIDTH  current Q(s,a).
- in_idx  in  ADDR_WIDTH  Q-table index of (s,a).
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_q_new  out  DATA_WIDTH  updated Q value.
- out_idx  out  ADDR_WIDTH  index carried through from the input.
- out_sat  out  1  final add saturated for this result.
- update_count  out  32  number of results accepted downstream; wraps at 2^32.

Behaviour:
- Interface decision: one clock; reset is synchronous and active-high (clk, rst).
- Reset: all stage valid bits, out_valid, out_q_new, out_idx, out_sat and update_count go to 0. Reset overrides en and discards in-flight data. in_ready is 0 while rst=1.
- Pipeline advance: adv = en && (!out_valid || out_ready). in_ready = adv. All four stages move together on adv (global stall, no bubble collapsing).
- Input acceptance: a tuple is accepted on a rising edge where in_valid && in_ready.
- Output: out_valid rises on the 4th adv edge after acceptance. Output is held stable while out_valid && !out_ready.
- Stage R1: g = (GAMMA * max_q) >>> FRAC_BITS, using the full 2*DATA_WIDTH signed product and an arithmetic shift (truncation toward -inf). R, Q and idx are registered alongside g.
- Stage R2: td = R + g - Q, computed at DATA_WIDTH+2 bits with no intermediate overflow.
- Stage R3: d = (ALPHA * td) >>> FRAC_BITS, full-width product with the same truncation; d is kept at DATA_WIDTH+2 bits.
- Stage R4: s = Q + d at DATA_WIDTH+3 bits, then clamped to [-2^(W-1), 2^(W-1)-1]. out_sat = 1 iff clamping occurred.
- Bubbles: each stage carries a valid bit; invalid stages advance as bubbles. Datapath registers may update with don't-care data when their stage is invalid.
- Counter: update_count increments on every edge with out_valid && out_ready && en.
- en=0: nothing changes, including update_count. in_ready = 0.
- Simultaneous accept and drain under back-pressure release: in the same edge a new tuple is accepted and the output tuple is consumed. No loss, no duplication.
- Mid-operation reset: reset on any cycle flushes the pipeline; no out_valid is produced for tuples accepted before the reset.

Test Plan:
- Nominal: R=0x00010000, max_q=0x00020000, Q=0x00000000, idx=5 -> 4 cycles later out_q_new=0x000047AC, out_idx=5, out_sat=0, update_count=1 after handshake.
- Negative reward: R=0xFFFF0000, max_q=0, Q=0 -> out_q_new=0xFFFFE667, out_sat=0.
- Saturation: R=max_q=Q=0x7FFF0000 -> out_q_new=0x7FFFFFFF, out_sat=1. Mirrored case with all three at 0x80000000 -> 0x80000000 with out_sat=1.
- Back-pressure: stream 8 tuples back-to-back with out_ready held 0 from cycle 6 to 10. Required: no tuple lost or duplicated, order preserved, in_ready=0 while stalled with out_valid=1, update_count=8 at end.
- Enable/reset: deassert en for 3 cycles mid-stream -> all outputs frozen, counter unchanged. Assert rst with 3 tuples in flight -> out_valid stays 0 afterwards and update_count=0.

Source files
------------

// File: rtl/q_update_core.sv
// Four-stage Q-learning update: Q_new = Q + ALPHA*(R + GAMMA*max_q - Q) in signed
// fixed point, saturated to DATA_WIDTH, with a global-stall valid/ready pipeline.
module q_update_core #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    FRAC_BITS  = 16,
  parameter int                    ADDR_WIDTH = 10,
  parameter logic [DATA_WIDTH-1:0] ALPHA      = 32'h0000_1999,
  parameter logic [DATA_WIDTH-1:0] GAMMA      = 32'h0000_E666
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_reward,
  input  logic [DATA_WIDTH-1:0] in_max_q,
  input  logic [DATA_WIDTH-1:0] in_q_old,
  input  logic [ADDR_WIDTH-1:0] in_idx,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_q_new,
  output logic [ADDR_WIDTH-1:0] out_idx,
  output logic                  out_sat,
  output logic [31:0]           update_count
);

  localparam int W  = DATA_WIDTH;
  localparam int TW = DATA_WIDTH + 2;
  localparam int SW = DATA_WIDTH + 3;

  // Clamp a widened sum to W bits; MSB of the result is the saturation flag.
  function automatic logic [W:0] sat_fn(input logic [SW-1:0] s);
    logic [W:0] res;
    if ((&s[SW-1:W-1]) || ~(|s[SW-1:W-1])) begin
      res = {1'b0, s[W-1:0]};
    end else if (s[SW-1]) begin
      res = {1'b1, 1'b1, {(W-1){1'b0}}};
    end else begin
      res = {1'b1, 1'b0, {(W-1){1'b1}}};
    end
    return res;
  endfunction

  logic                  adv_s;
  logic                  v1_r, v2_r, v3_r;
  logic [W-1:0]          g1_r, r1_r, q1_r, q2_r, q3_r;
  logic [ADDR_WIDTH-1:0] idx1_r, idx2_r, idx3_r;
  logic [TW-1:0]         td2_r, d3_r;
  logic                  out_valid_r, out_sat_r;
  logic [W-1:0]          out_q_new_r;
  logic [ADDR_WIDTH-1:0] out_idx_r;
  logic [31:0]           update_count_r;

  logic signed [2*W-1:0]  g_prod_s;
  logic [W-1:0]           g_s;
  logic [TW-1:0]          td_s;
  logic signed [2*TW-1:0] d_prod_s;
  logic [TW-1:0]          d_s;
  logic [SW-1:0]          s_sum_s;
  logic [W:0]             sat_res_s;

  assign adv_s    = en && (!out_valid_r || out_ready);
  assign in_ready = adv_s && !rst;

  // Datapath arithmetic feeding each pipeline register.
  always_comb begin
    g_prod_s  = $signed({{W{GAMMA[W-1]}}, GAMMA}) * $signed({{W{in_max_q[W-1]}}, in_max_q});
    g_s       = W'(g_prod_s >>> FRAC_BITS);
    td_s      = {{2{r1_r[W-1]}}, r1_r} + {{2{g1_r[W-1]}}, g1_r} - {{2{q1_r[W-1]}}, q1_r};
    d_prod_s  = $signed({{(TW+2){ALPHA[W-1]}}, ALPHA}) * $signed({{TW{td2_r[TW-1]}}, td2_r});
    d_s       = TW'(d_prod_s >>> FRAC_BITS);
    s_sum_s   = {{3{q3_r[W-1]}}, q3_r} + {d3_r[TW-1], d3_r};
    sat_res_s = sat_fn(s_sum_s);
  end

  // Pipeline stages; all advance together on adv_s, reset flushes everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_r        <= 1'b0;
      v2_r        <= 1'b0;
      v3_r        <= 1'b0;
      g1_r        <= '0;
      r1_r        <= '0;
      q1_r        <= '0;
      idx1_r      <= '0;
      td2_r       <= '0;
      q2_r        <= '0;
      idx2_r      <= '0;
      d3_r        <= '0;
      q3_r        <= '0;
      idx3_r      <= '0;
      out_valid_r <= 1'b0;
      out_q_new_r <= '0;
      out_idx_r   <= '0;
      out_sat_r   <= 1'b0;
    end else if (adv_s) begin
      v1_r        <= in_valid;
      g1_r        <= g_s;
      r1_r        <= in_reward;
      q1_r        <= in_q_old;
      idx1_r      <= in_idx;
      v2_r        <= v1_r;
      td2_r       <= td_s;
      q2_r        <= q1_r;
      idx2_r      <= idx1_r;
      v3_r        <= v2_r;
      d3_r        <= d_s;
      q3_r        <= q2_r;
      idx3_r      <= idx2_r;
      out_valid_r <= v3_r;
      out_q_new_r <= sat_res_s[W-1:0];
      out_sat_r   <= sat_res_s[W];
      out_idx_r   <= idx3_r;
    end
  end

  // Count results consumed downstream.
  always_ff @(posedge clk) begin
    if (rst) begin
      update_count_r <= 32'd0;
    end else if (en && out_valid_r && out_ready) begin
      update_count_r <= update_count_r + 32'd1;
    end
  end

  assign out_valid    = out_valid_r;
  assign out_q_new    = out_q_new_r;
  assign out_idx      = out_idx_r;
  assign out_sat      = out_sat_r;
  assign update_count = update_count_r;

endmodule

// File: tb/tb_q_update_core.sv
// Bench for q_update_core: directed table, hand sequences for stall/enable/reset,
// and random traffic scored against an integer-arithmetic reference model.
module tb_q_update_core;

  logic        clk = 1'b0;
  logic        rst, en, in_valid, in_ready, out_valid, out_ready, out_sat;
  logic [31:0] in_reward, in_max_q, in_q_old, out_q_new, update_count;
  logic [9:0]  in_idx, out_idx;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  q_update_core dut (
    .clk(clk), .rst(rst), .en(en),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_reward(in_reward), .in_max_q(in_max_q), .in_q_old(in_q_old), .in_idx(in_idx),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_q_new(out_q_new), .out_idx(out_idx), .out_sat(out_sat),
    .update_count(update_count)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain 64-bit integer arithmetic on the update formula.
  function automatic void ref_update(input logic [31:0] r, input logic [31:0] mq,
                                     input logic [31:0] q, output logic [31:0] qn,
                                     output logic sat);
    longint rl, ml, ql, g, td, d, s;
    rl = longint'($signed(r));
    ml = longint'($signed(mq));
    ql = longint'($signed(q));
    g  = (longint'(32'h0000_E666) * ml) >>> 16;
    td = rl + g - ql;
    d  = (longint'(32'h0000_1999) * td) >>> 16;
    s  = ql + d;
    if (s > 64'sd2147483647) begin
      qn = 32'h7FFF_FFFF; sat = 1'b1;
    end else if (s < -64'sd2147483648) begin
      qn = 32'h8000_0000; sat = 1'b1;
    end else begin
      qn = s[31:0]; sat = 1'b0;
    end
  endfunction

  function automatic logic [31:0] rand_val();
    logic [31:0] v;
    case ($urandom_range(0, 3))
      0: v = $urandom;
      1: begin v = $urandom_range(0, 32'h0003_FFFF); v = v - 32'h0002_0000; end
      2: v = ($urandom_range(0, 1) == 1) ? 32'h7FFF_FFFF : 32'h8000_0000;
      default: v = $urandom;
    endcase
    return v;
  endfunction

  typedef struct { logic [31:0] q; logic sat; logic [9:0] idx; } exp_t;
  exp_t        sb[$];
  int unsigned exp_cnt = 0;
  bit          mon_on = 1'b0;
  logic        hold_prev = 1'b0;
  logic        snap_v, snap_s;
  logic [31:0] snap_q;
  logic [9:0]  snap_i;

  // Scoreboard / protocol monitor, sampling on the inactive edge.
  always @(negedge clk) begin
    exp_t        e;
    logic [31:0] qn;
    logic        sat;
    if (mon_on) begin
      if (hold_prev) begin
        chk("hold_out_valid", out_valid, snap_v);
        chk("hold_out_q_new", out_q_new, snap_q);
        chk("hold_out_idx", out_idx, snap_i);
        chk("hold_out_sat", out_sat, snap_s);
      end
      chk("update_count", update_count, exp_cnt);
      chk("in_ready_rule", in_ready, en && (!out_valid || out_ready) && !rst);
      hold_prev = !rst && (!en || (out_valid && !out_ready));
      snap_v = out_valid; snap_q = out_q_new; snap_i = out_idx; snap_s = out_sat;
      if (rst) begin
        sb.delete();
        exp_cnt = 0;
      end else if (en) begin
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            chk("spurious_out_valid", out_valid, 1'b0);
          end else begin
            e = sb.pop_front();
            chk("sb_q_new", out_q_new, e.q);
            chk("sb_sat", out_sat, e.sat);
            chk("sb_idx", out_idx, e.idx);
          end
          exp_cnt++;
        end
        if (in_valid && in_ready) begin
          ref_update(in_reward, in_max_q, in_q_old, qn, sat);
          e.q = qn; e.sat = sat; e.idx = in_idx;
          sb.push_back(e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rand_tuple(input logic [9:0] idx);
    in_reward = rand_val();
    in_max_q  = rand_val();
    in_q_old  = rand_val();
    in_idx    = idx;
  endtask

  typedef struct {
    logic [31:0] r, mq, q;
    logic [9:0]  idx;
    logic [31:0] exp_q;
    logic        exp_sat;
  } vec_t;
  vec_t vecs[4];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          sent;
    int          base;
    logic        fire;
    logic [31:0] cnt_snap, q_snap;
    logic        v_snap;

    vecs[0] = '{32'h0001_0000, 32'h0002_0000, 32'h0000_0000, 10'd5, 32'h0000_47AC, 1'b0};
    vecs[1] = '{32'hFFFF_0000, 32'h0000_0000, 32'h0000_0000, 10'd6, 32'hFFFF_E667, 1'b0};
    vecs[2] = '{32'h7FFF_0000, 32'h7FFF_0000, 32'h7FFF_0000, 10'd7, 32'h7FFF_FFFF, 1'b1};
    vecs[3] = '{32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 10'd8, 32'h8000_0000, 1'b1};

    rst = 1'b1; en = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_reward = 32'd0; in_max_q = 32'd0; in_q_old = 32'd0; in_idx = 10'd0;
    tick(); tick();
    @(negedge clk);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_q_new", out_q_new, 32'd0);
    chk("rst_out_idx", out_idx, 10'd0);
    chk("rst_out_sat", out_sat, 1'b0);
    chk("rst_update_count", update_count, 32'd0);
    chk("rst_in_ready", in_ready, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    mon_on = 1'b1;

    // Directed table: single tuples with latency and value checks.
    for (int i = 0; i < 4; i++) begin
      base = update_count;
      in_reward = vecs[i].r; in_max_q = vecs[i].mq; in_q_old = vecs[i].q; in_idx = vecs[i].idx;
      in_valid = 1'b1;
      @(negedge clk);
      chk("dir_in_ready", in_ready, 1'b1);
      tick();
      in_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        chk("dir_latency_early", out_valid, 1'b0);
        tick();
      end
      @(negedge clk);
      chk("dir_out_valid", out_valid, 1'b1);
      chk("dir_q_new", out_q_new, vecs[i].exp_q);
      chk("dir_sat", out_sat, vecs[i].exp_sat);
      chk("dir_idx", out_idx, vecs[i].idx);
      tick();
      @(negedge clk);
      chk("dir_count", update_count, 32'(base + 1));
      chk("dir_drained", out_valid, 1'b0);
      tick();
    end

    // Back-pressure: 8 back-to-back tuples, out_ready low in cycles 6..10.
    rst = 1'b1; tick(); rst = 1'b0;
    sent = 0;
    for (int c = 0; c < 40; c++) begin
      out_ready = !(c >= 6 && c <= 10);
      in_valid  = (sent < 8);
      set_rand_tuple(10'(100 + sent));
      @(negedge clk);
      if (out_valid && !out_ready) chk("bp_stall_in_ready", in_ready, 1'b0);
      fire = in_valid && in_ready;
      tick();
      if (fire) sent++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("bp_update_count", update_count, 32'd8);
    chk("bp_idle", out_valid, 1'b0);
    tick();

    // Enable low for three cycles mid-stream freezes everything.
    for (int c = 0; c < 12; c++) begin
      en = !(c >= 5 && c <= 7);
      in_valid = 1'b1;
      set_rand_tuple(10'(200 + c));
      @(negedge clk);
      if (c == 5) begin
        cnt_snap = update_count; q_snap = out_q_new; v_snap = out_valid;
        chk("en_low_in_ready", in_ready, 1'b0);
      end
      if (c == 8) begin
        chk("en_frozen_count", update_count, cnt_snap);
        chk("en_frozen_q_new", out_q_new, q_snap);
        chk("en_frozen_valid", out_valid, v_snap);
      end
      tick();
    end
    in_valid = 1'b0; en = 1'b1;
    for (int k = 0; k < 6; k++) tick();

    // Reset with three tuples in flight flushes them and clears the counter.
    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1;
      set_rand_tuple(10'(300 + c));
      tick();
    end
    in_valid = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("rst_flush_valid", out_valid, 1'b0);
      chk("rst_flush_count", update_count, 32'd0);
      tick();
    end

    // Random traffic against the reference model.
    for (int c = 0; c < 400; c++) begin
      en        = ($urandom_range(0, 9) != 0);
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      set_rand_tuple(10'($urandom));
      tick();
    end
    en = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 20 && (sb.size() != 0 || out_valid); k++) tick();
    @(negedge clk);
    chk("drain_empty", sb.size(), 0);
    chk("drain_out_valid", out_valid, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
